noc_ni_4x4_32b: RTL and testbench
=================================

Name: noc_ni_4x4_32b

Overview:
- Network interface between a local core and one port of a 4x4 32-bit mesh router node.
- Transmit side: buffers core-issued packets (5-bit destination address + 32-bit data) and drives them into the router's input port using the valid/ack handshake.
- Receive side: accepts packets from the router's output port, acknowledges them, and buffers them for the core.
- One instance per mesh node, attached to that node's local port.

Parameters:
- NODE_ADDR, 5'd7: this node's mesh address (router address encoding); used only by the optional feature.
- TX_DEPTH, 4: transmit FIFO entries; power of two, 2..16.
- RX_DEPTH, 4: receive FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- tx_wr_en  input  1  core push into TX FIFO.
- tx_wr_addr  input  5  destination address.
- tx_wr_data  input  32  payload.
- tx_full  output  1  TX FIFO full.
- rx_rd_en  input  1  core pop from RX FIFO.
- rx_addr  output  5  RX FIFO head address.
- rx_data  output  32  RX FIFO head data.
- rx_empty  output  1  RX FIFO empty.
- out_addr  output  5  to router in_addr.
- out_data  output  32  to router in_data.
- out_valid  output  1  to router in_valid.
- from_out_ack  input  1  from router to_in_ack.
- in_addr  input  5  from router out_addr.
- in_data  input  32  from router out_data.
- in_valid  input  1  from router out_valid.
- to_in_ack  output  1  to router from_out_ack.

Behaviour:
- Reset (rst low, asynchronous): both FIFOs empty; both FSMs in IDLE. Outputs: out_valid=0, out_addr=0, out_data=0, to_in_ack=0, tx_full=0, rx_empty=1.
- Reset asserted mid-transfer aborts immediately; in-flight and buffered packets are lost.
- TX FIFO: push when tx_wr_en && !tx_full.
  - Push while full is ignored; contents are unchanged.
  - Push and pop in the same cycle are both legal; count is unchanged.
- TX FSM:
  - IDLE: if FIFO non-empty, load head into out_addr/out_data, set out_valid=1, go to SEND. First valid cycle is the cycle after the push edge (1-cycle latency from an empty FIFO).
  - SEND: hold addr/data/valid stable. When from_out_ack=1 at an edge: pop, clear out_valid, go to GAP.
  - GAP: out_valid=0 for exactly one cycle, then IDLE. This guarantees the router sees valid low between packets.
  - Back-to-back packets therefore appear no faster than one per 3 cycles (valid, ack edge, gap).
  - from_out_ack in IDLE or GAP is ignored.
  - out_addr/out_data hold their last value when out_valid=0.
- RX FSM:
  - IDLE: if in_valid=1 and RX FIFO not full at an edge: push {in_addr, in_data}, drive to_in_ack=1, go to ACK.
  - ACK: to_in_ack high for exactly one cycle, then drop, go to HOLD.
  - HOLD: wait for in_valid=0, then IDLE. The same flit is never captured twice.
  - RX FIFO full: no ack and no capture; the router stalls with valid held. Capture occurs on the first edge after a pop frees space.
- rx_addr/rx_data show the FIFO head combinationally. rx_rd_en while rx_empty is ignored. A pop and a push in the same cycle are both legal.
- Address is passed through unmodified on both sides; no routing decisions are made here.

Optional Feature:
- Macro NOC_NI_STATS_EN.
- Defined: adds outputs tx_count[15:0], rx_count[15:0] and misroute_count[7:0].
  - tx_count: +1 per TX ack.
  - rx_count: +1 per RX capture.
  - misroute_count: +1 per captured flit with in_addr != NODE_ADDR.
  - All counters wrap modulo 2^width and are cleared by reset.
- Undefined: no such ports or logic; all other behaviour is identical.

Test Plan:
- Reset, then push (addr 5'd20, data 32'hDEADBEEF); ack 2 cycles after valid rises → out_valid high for 3 cycles with stable addr/data, low in the ack-following cycle, tx_full=0, FIFO empty.
- Push 5 packets into TX_DEPTH=4 with no ack → tx_full=1 after the 4th push, 5th ignored. Then ack each → exactly 4 packets sent in order, each separated by ≥1 valid-low cycle.
- Router drives in_valid=1 (addr 5'd7, data 32'h12345678) and holds it for 4 cycles → to_in_ack a single 1-cycle pulse, exactly one RX entry, rx_addr=7, rx_data=32'h12345678.
- Fill RX FIFO (4 flits, no pops), then present a 5th → to_in_ack stays 0. Pop one → the 5th is captured and acked on the next edge.
- Assert rst low mid-SEND with out_valid=1 → out_valid=0 immediately (before the next clk edge), FIFOs empty, and no ack generated after release.
- With NOC_NI_STATS_EN defined, NODE_ADDR=7: send 2 packets, receive flits with addr 7, 7, 9 → tx_count=2, rx_count=3, misroute_count=1.

Source files
------------

// File: rtl/noc_ni_4x4_32b.sv
// Network interface between a local core and one mesh-router port: TX/RX FIFOs plus handshake FSMs.
// Define NOC_NI_STATS_EN to add the tx_count/rx_count/misroute_count statistics outputs.
module noc_ni_4x4_32b #(
    parameter logic [4:0]  NODE_ADDR = 5'd7,
    parameter int unsigned TX_DEPTH  = 4,
    parameter int unsigned RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_wr_en,
    input  logic [4:0]  tx_wr_addr,
    input  logic [31:0] tx_wr_data,
    output logic        tx_full,
    input  logic        rx_rd_en,
    output logic [4:0]  rx_addr,
    output logic [31:0] rx_data,
    output logic        rx_empty,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        from_out_ack,
    input  logic [4:0]  in_addr,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        to_in_ack
`ifdef NOC_NI_STATS_EN
    ,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic [7:0]  misroute_count
`endif
);
    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_CNT_FULL = TX_DEPTH[TX_AW:0];
    localparam logic [RX_AW:0] RX_CNT_FULL = RX_DEPTH[RX_AW:0];
    localparam logic [TX_AW:0] TX_PTR_INC = {{TX_AW{1'b0}}, 1'b1};
    localparam logic [RX_AW:0] RX_PTR_INC = {{RX_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {TxIdle, TxSend, TxGap} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxAck, RxHold} rx_state_e;

    // FIFO entries are {addr[4:0], data[31:0]}
    logic [36:0]    r_tx_mem [TX_DEPTH];
    logic [TX_AW:0] r_tx_wptr, r_tx_rptr;
    logic [TX_AW:0] w_tx_cnt;
    logic           w_tx_push, w_tx_pop, w_tx_empty;
    tx_state_e      r_tx_state;
    logic [4:0]     r_out_addr;
    logic [31:0]    r_out_data;
    logic           r_out_valid;

    logic [36:0]    r_rx_mem [RX_DEPTH];
    logic [RX_AW:0] r_rx_wptr, r_rx_rptr;
    logic [RX_AW:0] w_rx_cnt;
    logic           w_rx_push, w_rx_pop, w_rx_full;
    rx_state_e      r_rx_state;
    logic           r_to_in_ack;

    assign w_tx_cnt   = r_tx_wptr - r_tx_rptr;
    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign tx_full    = (w_tx_cnt == TX_CNT_FULL);
    assign w_tx_push  = tx_wr_en && !tx_full;
    assign w_tx_pop   = (r_tx_state == TxSend) && from_out_ack;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr[TX_AW-1:0]] <= {tx_wr_addr, tx_wr_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_PTR_INC;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_PTR_INC;
        end
    end

    // The head stays in the FIFO until acked, so a reset mid-SEND drops it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state  <= TxIdle;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            unique case (r_tx_state)
                TxIdle: if (!w_tx_empty) begin
                    {r_out_addr, r_out_data} <= r_tx_mem[r_tx_rptr[TX_AW-1:0]];
                    r_out_valid              <= 1'b1;
                    r_tx_state               <= TxSend;
                end
                TxSend: if (from_out_ack) begin
                    r_out_valid <= 1'b0;
                    r_tx_state  <= TxGap;
                end
                TxGap:   r_tx_state <= TxIdle;
                default: begin
                    r_out_valid <= 1'b0;
                    r_tx_state  <= TxIdle;
                end
            endcase
        end
    end

    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    assign w_rx_cnt  = r_rx_wptr - r_rx_rptr;
    assign rx_empty  = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full = (w_rx_cnt == RX_CNT_FULL);
    assign w_rx_push = (r_rx_state == RxIdle) && in_valid && !w_rx_full;
    assign w_rx_pop  = rx_rd_en && !rx_empty;
    assign {rx_addr, rx_data} = r_rx_mem[r_rx_rptr[RX_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr[RX_AW-1:0]] <= {in_addr, in_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_PTR_INC;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_PTR_INC;
        end
    end

    // HOLD waits for valid to fall so a flit the router keeps presenting is captured once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state  <= RxIdle;
            r_to_in_ack <= 1'b0;
        end else begin
            unique case (r_rx_state)
                RxIdle: if (w_rx_push) begin
                    r_to_in_ack <= 1'b1;
                    r_rx_state  <= RxAck;
                end
                RxAck: begin
                    r_to_in_ack <= 1'b0;
                    r_rx_state  <= RxHold;
                end
                RxHold:  if (!in_valid) r_rx_state <= RxIdle;
                default: begin
                    r_to_in_ack <= 1'b0;
                    r_rx_state  <= RxIdle;
                end
            endcase
        end
    end

    assign to_in_ack = r_to_in_ack;

`ifdef NOC_NI_STATS_EN
    logic [15:0] r_tx_count, r_rx_count;
    logic [7:0]  r_misroute_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_count       <= '0;
            r_rx_count       <= '0;
            r_misroute_count <= '0;
        end else begin
            if (w_tx_pop)  r_tx_count <= r_tx_count + 16'd1;
            if (w_rx_push) r_rx_count <= r_rx_count + 16'd1;
            if (w_rx_push && (in_addr != NODE_ADDR)) r_misroute_count <= r_misroute_count + 8'd1;
        end
    end

    assign tx_count       = r_tx_count;
    assign rx_count       = r_rx_count;
    assign misroute_count = r_misroute_count;
`else
    logic w_unused_node_addr;
    assign w_unused_node_addr = ^NODE_ADDR;
`endif

endmodule

// File: tb/tb_noc_ni_4x4_32b.sv
// Self-checking bench for noc_ni_4x4_32b: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_noc_ni_4x4_32b;
    localparam int unsigned TX_DEPTH = 4;
    localparam int unsigned RX_DEPTH = 4;
    localparam logic [4:0]  NODE     = 5'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_wr_en = 1'b0;
    logic [4:0]  tx_wr_addr = '0;
    logic [31:0] tx_wr_data = '0;
    logic        tx_full;
    logic        rx_rd_en = 1'b0;
    logic [4:0]  rx_addr;
    logic [31:0] rx_data;
    logic        rx_empty;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_valid;
    logic        from_out_ack = 1'b0;
    logic [4:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        to_in_ack;
`ifdef NOC_NI_STATS_EN
    logic [15:0] tx_count, rx_count;
    logic [7:0]  misroute_count;
`endif

    noc_ni_4x4_32b #(
        .NODE_ADDR(NODE),
        .TX_DEPTH (TX_DEPTH),
        .RX_DEPTH (RX_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_wr_en    (tx_wr_en),
        .tx_wr_addr  (tx_wr_addr),
        .tx_wr_data  (tx_wr_data),
        .tx_full     (tx_full),
        .rx_rd_en    (rx_rd_en),
        .rx_addr     (rx_addr),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .from_out_ack(from_out_ack),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .to_in_ack   (to_in_ack)
`ifdef NOC_NI_STATS_EN
        ,
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .misroute_count(misroute_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: packets are queues; timing is counted in clock edges.
    logic [36:0] m_txq[$];
    logic [36:0] m_rxq[$];
    logic [36:0] m_last = '0;
    logic        m_valid = 1'b0;
    logic        m_ack = 1'b0;
    logic        m_seen = 1'b0;
    int          m_cyc = 0, m_tx_next = 0, m_cap = 0;
    int          m_sz, m_rsz;
    bit          m_push, m_pop;
    int          m_txcnt = 0, m_rxcnt = 0, m_miscnt = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_txq.delete();
            m_rxq.delete();
            m_last = '0; m_valid = 1'b0; m_ack = 1'b0; m_seen = 1'b0;
            m_cyc = 0; m_tx_next = 0; m_cap = 0;
            m_txcnt = 0; m_rxcnt = 0; m_miscnt = 0;
        end else begin
            m_cyc++;
            // Transmit: a packet is offered once the earliest-offer edge has come, held until acked.
            m_sz   = m_txq.size();
            m_push = tx_wr_en && (m_sz < TX_DEPTH);
            if (m_valid && from_out_ack) begin
                void'(m_txq.pop_front());
                m_valid   = 1'b0;
                m_tx_next = m_cyc + 2;
                m_txcnt++;
            end else if (!m_valid && m_sz > 0 && m_cyc >= m_tx_next) begin
                m_valid = 1'b1;
                m_last  = m_txq[0];
            end
            if (m_push) m_txq.push_back({tx_wr_addr, tx_wr_data});
            // Receive: one capture per valid assertion, ack pulse lasts a single cycle.
            m_rsz = m_rxq.size();
            m_pop = rx_rd_en && (m_rsz > 0);
            m_ack = 1'b0;
            if (!m_seen && in_valid && m_rsz < RX_DEPTH) begin
                m_rxq.push_back({in_addr, in_data});
                m_ack  = 1'b1;
                m_seen = 1'b1;
                m_cap  = m_cyc;
                m_rxcnt++;
                if (in_addr != NODE) m_miscnt++;
            end else if (m_seen && m_cyc >= m_cap + 2 && !in_valid) begin
                m_seen = 1'b0;
            end
            if (m_pop) void'(m_rxq.pop_front());
        end
    end

    logic [36:0] c_head;
    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", out_valid, m_valid);
            chk("out_addr", out_addr, m_last[36:32]);
            chk("out_data", out_data, m_last[31:0]);
            chk("tx_full", tx_full, m_txq.size() == TX_DEPTH);
            chk("to_in_ack", to_in_ack, m_ack);
            chk("rx_empty", rx_empty, m_rxq.size() == 0);
            if (m_rxq.size() != 0) begin
                c_head = m_rxq[0];
                chk("rx_addr", rx_addr, c_head[36:32]);
                chk("rx_data", rx_data, c_head[31:0]);
            end
`ifdef NOC_NI_STATS_EN
            chk("tx_count", tx_count, 16'(m_txcnt));
            chk("rx_count", rx_count, 16'(m_rxcnt));
            chk("misroute_count", misroute_count, 8'(m_miscnt));
`endif
        end
    end

    task automatic wait_valid();
        for (int i = 0; i < 16 && !out_valid; i++) @(negedge clk);
        chk("tx_valid_seen", out_valid, 1);
    endtask

    task automatic send_flit(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1; in_addr = a; in_data = d;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (to_in_ack) break;
        end
        chk("flit_acked", to_in_ack, 1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_tx(input logic [4:0] a, input logic [31:0] d);
        tx_wr_en = 1'b1; tx_wr_addr = a; tx_wr_data = d;
        @(negedge clk);
        tx_wr_en = 1'b0;
    endtask

    logic [31:0] pd [5];
    logic [4:0]  t4_exp [4] = '{5'd11, 5'd12, 5'd13, 5'd21};
    int          n_ack;
    int          rt_gap;

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_to_in_ack", to_in_ack, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_empty", rx_empty, 1);
        #2 rst = 1'b1;
        @(negedge clk);

        // Single packet, ack raised after valid has been up for a while.
        tx_wr_en = 1'b1; tx_wr_addr = 5'd20; tx_wr_data = 32'hDEADBEEF;
        @(negedge clk);
        tx_wr_en = 1'b0;
        chk("t1_latency", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_valid_hi", out_valid, 1);
            chk("t1_addr", out_addr, 5'd20);
            chk("t1_data", out_data, 32'hDEADBEEF);
        end
        from_out_ack = 1'b1;
        @(negedge clk);
        from_out_ack = 1'b0;
        chk("t1_valid_lo", out_valid, 0);
        chk("t1_addr_hold", out_addr, 5'd20);
        chk("t1_tx_full", tx_full, 0);
        repeat (4) begin
            @(negedge clk);
            chk("t1_stays_idle", out_valid, 0);
        end
        chk("t1_model_empty", m_txq.size(), 0);

        // Overfill TX, then drain in order.
        for (int i = 0; i < 5; i++) begin
            tx_wr_en = 1'b1; tx_wr_addr = 5'(i * 3 + 1); tx_wr_data = $urandom;
            pd[i] = tx_wr_data;
            @(negedge clk);
            chk("t2_full_flag", tx_full, i >= 3);
        end
        tx_wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid();
            chk("t2_addr", out_addr, 5'(i * 3 + 1));
            chk("t2_data", out_data, pd[i]);
            from_out_ack = 1'b1;
            @(negedge clk);
            from_out_ack = 1'b0;
            chk("t2_gap", out_valid, 0);
        end
        repeat (6) begin
            @(negedge clk);
            chk("t2_no_fifth", out_valid, 0);
        end
        chk("t2_not_full", tx_full, 0);

        // Router holds valid for 4 cycles: exactly one capture.
        in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h12345678;
        n_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (to_in_ack) n_ack++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (to_in_ack) n_ack++;
        end
        chk("t3_ack_pulses", n_ack, 1);
        chk("t3_model_depth", m_rxq.size(), 1);
        chk("t3_rx_empty", rx_empty, 0);
        chk("t3_rx_addr", rx_addr, 5'd7);
        chk("t3_rx_data", rx_data, 32'h12345678);
        rx_rd_en = 1'b1;
        repeat (2) @(negedge clk);
        rx_rd_en = 1'b0;
        chk("t3_popped", rx_empty, 1);

        // RX full: 5th flit stalls until a pop frees space.
        for (int i = 0; i < 4; i++) send_flit(5'(10 + i), $urandom);
        chk("t4_model_depth", m_rxq.size(), 4);
        in_valid = 1'b1; in_addr = 5'd21; in_data = 32'hCAFE0005;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_no_ack_full", to_in_ack, 0);
        end
        rx_rd_en = 1'b1;
        @(negedge clk);
        rx_rd_en = 1'b0;
        chk("t4_no_ack_pop_edge", to_in_ack, 0);
        @(negedge clk);
        chk("t4_ack_after_pop", to_in_ack, 1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t4_order", rx_addr, t4_exp[i]);
            rx_rd_en = 1'b1;
            @(negedge clk);
        end
        rx_rd_en = 1'b0;
        chk("t4_drained", rx_empty, 1);

        // Asynchronous reset in the middle of SEND.
        push_tx(5'd3, 32'h0000AAAA);
        push_tx(5'd4, 32'h0000BBBB);
        send_flit(5'd5, 32'h0000CCCC);
        chk("t5_pre_valid", out_valid, 1);
        chk("t5_pre_rx", rx_empty, 0);
        #2 rst = 1'b0;
        #1;
        chk("t5_valid_async", out_valid, 0);
        chk("t5_addr_async", out_addr, 0);
        chk("t5_data_async", out_data, 0);
        chk("t5_tx_full_async", tx_full, 0);
        chk("t5_rx_empty_async", rx_empty, 1);
        from_out_ack = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_ack", to_in_ack, 0);
            chk("t5_no_valid", out_valid, 0);
        end
        from_out_ack = 1'b0;

        // Statistics scenario: two sends, receive addresses 7, 7, 9.
        push_tx(5'd1, 32'h11111111);
        push_tx(5'd2, 32'h22222222);
        for (int i = 0; i < 2; i++) begin
            wait_valid();
            from_out_ack = 1'b1;
            @(negedge clk);
            from_out_ack = 1'b0;
        end
        send_flit(5'd7, 32'h70);
        send_flit(5'd7, 32'h71);
        send_flit(5'd9, 32'h90);
        chk("t6_model_txcnt", m_txcnt, 2);
        chk("t6_model_miscnt", m_miscnt, 1);
`ifdef NOC_NI_STATS_EN
        chk("t6_tx_count", tx_count, 16'd2);
        chk("t6_rx_count", rx_count, 16'd3);
        chk("t6_misroute", misroute_count, 8'd1);
`endif

        // Randomized traffic on both sides.
        rt_gap = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tx_wr_en     = ($urandom_range(0, 2) == 0);
            tx_wr_addr   = 5'($urandom);
            tx_wr_data   = $urandom;
            from_out_ack = out_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            rx_rd_en     = ($urandom_range(0, 3) == 0);
            if (in_valid) begin
                if (to_in_ack) begin
                    in_valid = 1'b0;
                    rt_gap   = 2 + int'($urandom_range(0, 3));
                end
            end else if (rt_gap > 0) begin
                rt_gap--;
            end else if ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b1;
                in_addr  = ($urandom_range(0, 1) == 0) ? NODE : 5'($urandom);
                in_data  = $urandom;
            end
        end
        tx_wr_en = 1'b0; from_out_ack = 1'b0; rx_rd_en = 1'b0; in_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
